// File: rtl/mem_access_unit.sv
// mem_access_unit: sub-word load/store front end for a 32-bit word-wide memory.
//
// A single request is accepted in IDLE. Loads read one word and extract the
// addressed lane with sign or zero extension. Word stores write directly.
// Byte and half stores do a read-modify-write through a merge register. The
// response is held until the consumer accepts it.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : a misaligned half/word access returns AddrErr=1 with no memory
//               strobe.
//   undefined : the offending low address bits are cleared, the access goes
//               ahead, and AddrErr is tied to 0.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   ReqValid/ReqReady request handshake
//   ReqWe, ReqSize,   request fields. ReqSize: 00 byte, 01 half, 1x word
//   ReqUnsigned,
//   ReqAddr, ReqData
//   RspValid/RspReady response handshake
//   RspData, AddrErr  load result (0 for stores and errors), misalignment flag
//   MemLoad, MemStore word memory read/write strobes (never both high)
//   MemAddress        word index, taken from the latched byte address
//   MemDataIn         write data, valid while MemStore is high
//   MemDataOut        combinational read data from the memory
module mem_access_unit #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWe,
  input  logic [1:0]        ReqSize,
  input  logic              ReqUnsigned,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [31:0]       ReqData,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [31:0]       RspData,
  output logic              AddrErr,
  output logic              MemLoad,
  output logic              MemStore,
  output logic [ADDR_W-3:0] MemAddress,
  output logic [31:0]       MemDataIn,
  input  logic [31:0]       MemDataOut
);

  typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StResp} state_e;

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        merge_q, merge_d;
  logic [31:0]        rsp_data_q, rsp_data_d;

  logic [ADDR_W-1:0]  req_addr_eff;
  logic               req_misalign;
  logic [7:0]         lane_byte;
  logic [15:0]        lane_half;
  logic [31:0]        load_ext;
  logic [31:0]        store_word;

  // Low address bits that an access of this size may not use are cleared.
  // Aligned addresses pass through unchanged, so the same value serves both
  // configurations.
  always_comb begin
    req_addr_eff = ReqAddr;
    if (ReqSize[1]) begin
      req_addr_eff[1:0] = 2'b00;
    end else if (ReqSize == 2'b01) begin
      req_addr_eff[0] = 1'b0;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic addr_err_q, addr_err_d;

  assign req_misalign = ReqSize[1] ? (ReqAddr[1:0] != 2'b00)
                                   : ((ReqSize == 2'b01) && ReqAddr[0]);
  assign AddrErr = addr_err_q;
`else
  assign req_misalign = 1'b0;
  assign AddrErr      = 1'b0;
`endif

  // Lane extraction from the memory read data (little-endian lanes).
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_byte = MemDataOut[7:0];
      2'd1:    lane_byte = MemDataOut[15:8];
      2'd2:    lane_byte = MemDataOut[23:16];
      default: lane_byte = MemDataOut[31:24];
    endcase
    lane_half = addr_q[1] ? MemDataOut[31:16] : MemDataOut[15:0];
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = uns_q ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_ext = MemDataOut;
    endcase
  end

  // Store word: the merge register with only the addressed lane(s) replaced.
  always_comb begin
    store_word = merge_q;
    case (size_q)
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    store_word[7:0]   = wdata_q[7:0];
          2'd1:    store_word[15:8]  = wdata_q[7:0];
          2'd2:    store_word[23:16] = wdata_q[7:0];
          default: store_word[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) begin
          store_word[31:16] = wdata_q[15:0];
        end else begin
          store_word[15:0] = wdata_q[15:0];
        end
      end
      default: store_word = wdata_q;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    merge_d    = merge_q;
    rsp_data_d = rsp_data_q;
`ifdef MISALIGN_TRAP_EN
    addr_err_d = addr_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (ReqValid) begin
          we_d       = ReqWe;
          size_d     = ReqSize;
          uns_d      = ReqUnsigned;
          addr_d     = req_addr_eff;
          wdata_d    = ReqData;
          rsp_data_d = 32'h0;
          if (req_misalign) begin
`ifdef MISALIGN_TRAP_EN
            addr_err_d = 1'b1;
`endif
            state_d = StResp;
          end else if (!ReqWe) begin
            state_d = StLoad;
          end else if (ReqSize[1]) begin
            merge_d = 32'h0;
            state_d = StWrite;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StLoad: begin
        rsp_data_d = load_ext;
        state_d    = StResp;
      end
      StRmwRd: begin
        merge_d = MemDataOut;
        state_d = StWrite;
      end
      StWrite: begin
        state_d = StResp;
      end
      StResp: begin
        if (RspReady) begin
          rsp_data_d = 32'h0;
`ifdef MISALIGN_TRAP_EN
          addr_err_d = 1'b0;
`endif
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      merge_q    <= 32'h0;
      rsp_data_q <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      addr_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      merge_q    <= merge_d;
      rsp_data_q <= rsp_data_d;
`ifdef MISALIGN_TRAP_EN
      addr_err_q <= addr_err_d;
`endif
    end
  end

  // All memory-side outputs come from registered state only.
  assign ReqReady   = (state_q == StIdle);
  assign RspValid   = (state_q == StResp);
  assign RspData    = rsp_data_q;
  assign MemLoad    = (state_q == StLoad) || (state_q == StRmwRd);
  assign MemStore   = (state_q == StWrite);
  assign MemAddress = addr_q[ADDR_W-1:2];
  assign MemDataIn  = (state_q == StWrite) ? store_word : 32'h0;

  // we_q is kept for completeness of the latched request; the path is
  // already encoded in the state.
  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver pushes the expected
// response of each request, and a negedge monitor pops and compares when a
// response appears. The monitor also measures latency and strobe activity.
module tb_mem_access_unit;

  localparam int unsigned ADDR_W = 12;

  logic              clk;
  logic              rst_n;
  logic              ReqValid, ReqReady, ReqWe, ReqUnsigned;
  logic [1:0]        ReqSize;
  logic [ADDR_W-1:0] ReqAddr;
  logic [31:0]       ReqData;
  logic              RspValid, RspReady, AddrErr;
  logic [31:0]       RspData;
  logic              MemLoad, MemStore;
  logic [ADDR_W-3:0] MemAddress;
  logic [31:0]       MemDataIn, MemDataOut;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqWe      (ReqWe),
    .ReqSize    (ReqSize),
    .ReqUnsigned(ReqUnsigned),
    .ReqAddr    (ReqAddr),
    .ReqData    (ReqData),
    .RspValid   (RspValid),
    .RspReady   (RspReady),
    .RspData    (RspData),
    .AddrErr    (AddrErr),
    .MemLoad    (MemLoad),
    .MemStore   (MemStore),
    .MemAddress (MemAddress),
    .MemDataIn  (MemDataIn),
    .MemDataOut (MemDataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory model.
  logic [31:0] mem [1024];
  assign MemDataOut = MemLoad ? mem[MemAddress] : 32'h0;
  always @(posedge clk) if (MemStore) mem[MemAddress] <= MemDataIn;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [7:0]  lat;
    logic [7:0]  nld;
    logic [7:0]  nst;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          rsp_cnt = 0;
  int          acc_cnt = 0;
  int          exp_acc = 0;
  int          both_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: all sampling on the falling edge.
  int          neg_n = 0;
  int          acc_n = 0;
  int          nld = 0;
  int          nst = 0;
  logic [31:0] wd = 32'h0;
  logic        rsp_seen = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    neg_n++;
    if (MemLoad) nld++;
    if (MemStore) begin
      nst++;
      wd = MemDataIn;
    end
    if (MemLoad && MemStore) both_cnt++;
    if (ReqValid && ReqReady) begin
      acc_n = neg_n;
      nld = 0;
      nst = 0;
      acc_cnt++;
    end
    if (!RspValid) begin
      rsp_seen = 1'b0;
    end else if (!rsp_seen) begin
      rsp_seen = 1'b1;
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: got RspData 0x%08h, expected no response", RspData);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", RspData, e.data);
        chk("addr_err", {31'h0, AddrErr}, {31'h0, e.err});
        chk("latency", neg_n - acc_n, {24'h0, e.lat});
        chk("load_strobes", nld, {24'h0, e.nld});
        chk("store_strobes", nst, {24'h0, e.nst});
        if (e.nst != 0) chk("store_wdata", wd, e.wdata);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    ReqValid = 1'b1; ReqWe = we; ReqSize = sz; ReqUnsigned = uns;
    ReqAddr = addr; ReqData = data;
    exp_acc++;
    @(posedge clk); #1;
    ReqValid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_cnt >= target) break;
    end
    if (rsp_cnt < target) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rsp_timeout: got %0d responses, expected %0d", rsp_cnt, target);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic err, input logic [7:0] lat,
                      input logic [7:0] l, input logic [7:0] s, input logic [31:0] w);
    exp_t e;
    e.data = d; e.err = err; e.lat = lat; e.nld = l; e.nst = s; e.wdata = w;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'h0, ReqReady}, 32'h1);
    chk({tag, "_rsp_valid"}, {31'h0, RspValid}, 32'h0);
    chk({tag, "_rsp_data"}, RspData, 32'h0);
    chk({tag, "_addr_err"}, {31'h0, AddrErr}, 32'h0);
    chk({tag, "_mem_load"}, {31'h0, MemLoad}, 32'h0);
    chk({tag, "_mem_store"}, {31'h0, MemStore}, 32'h0);
    chk({tag, "_mem_addr"}, {22'h0, MemAddress}, 32'h0);
    chk({tag, "_mem_wdata"}, MemDataIn, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[2] = 32'h11223344;
    mem[4] = 32'hA5A5A5A5;
    mem[5] = 32'h8899AABB;
    rst_n = 1'b1; ReqValid = 1'b0; ReqWe = 1'b0; ReqSize = 2'b00; ReqUnsigned = 1'b0;
    ReqAddr = '0; ReqData = 32'h0; RspReady = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    target = 0;

    // Byte load, signed: lane 2 of 0x8899AABB.
    push(32'hFFFFFF99, 1'b0, 8'd2, 8'd1, 8'd0, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 12'h016, 32'h0); wait_rsp(++target);
    // Half load, unsigned: upper half.
    push(32'h00008899, 1'b0, 8'd2, 8'd1, 8'd0, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 12'h016, 32'h0); wait_rsp(++target);
    // Byte store 0xCC into lane 1; upper ReqData bits must be ignored.
    push(32'h0, 1'b0, 8'd3, 8'd1, 8'd1, 32'h8899CCBB);
    issue(1'b1, 2'b00, 1'b0, 12'h015, 32'hFFFFFFCC); wait_rsp(++target);
    chk("mem5_after_sb", mem[5], 32'h8899CCBB);
    // Misaligned word load.
`ifdef MISALIGN_TRAP_EN
    push(32'h0, 1'b1, 8'd1, 8'd0, 8'd0, 32'h0);
`else
    push(32'h11223344, 1'b0, 8'd2, 8'd1, 8'd0, 32'h0);
`endif
    issue(1'b0, 2'b10, 1'b0, 12'h00A, 32'h0); wait_rsp(++target);
    // Word store, then sub-word loads and a half RMW on the same word.
    push(32'h0, 1'b0, 8'd2, 8'd0, 8'd1, 32'hDEADBEEF);
    issue(1'b1, 2'b10, 1'b0, 12'h01C, 32'hDEADBEEF); wait_rsp(++target);
    push(32'hFFFFDEAD, 1'b0, 8'd2, 8'd1, 8'd0, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 12'h01E, 32'h0); wait_rsp(++target);
    push(32'h000000DE, 1'b0, 8'd2, 8'd1, 8'd0, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 12'h01F, 32'h0); wait_rsp(++target);
    push(32'h0, 1'b0, 8'd3, 8'd1, 8'd1, 32'h1234BEEF);
    issue(1'b1, 2'b01, 1'b0, 12'h01E, 32'hFFFF1234); wait_rsp(++target);
    push(32'h1234BEEF, 1'b0, 8'd2, 8'd1, 8'd0, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 12'h01C, 32'h0); wait_rsp(++target);

    // Back-pressure: response held 4 cycles, stray ReqValid pulse ignored.
    RspReady = 1'b0;
    push(32'h8899CCBB, 1'b0, 8'd2, 8'd1, 8'd0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 12'h014, 32'h0); wait_rsp(++target);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        ReqValid = 1'b1; ReqWe = 1'b1; ReqSize = 2'b10; ReqAddr = 12'h000;
        ReqData = 32'hFFFFFFFF;
      end else begin
        ReqValid = 1'b0;
      end
      @(negedge clk);
      chk("hold_rsp_valid", {31'h0, RspValid}, 32'h1);
      chk("hold_rsp_data", RspData, 32'h8899CCBB);
      chk("hold_req_ready", {31'h0, ReqReady}, 32'h0);
    end
    @(posedge clk); #1;
    ReqValid = 1'b0; RspReady = 1'b1;
    @(posedge clk); #1;
    chk("post_hold_req_ready", {31'h0, ReqReady}, 32'h1);
    chk("post_hold_rsp_valid", {31'h0, RspValid}, 32'h0);
    repeat (2) @(posedge clk); #1;
    chk("stray_req_no_write", mem[0], 32'h0);

    // Reset during the WRITE of a byte store.
    issue(1'b1, 2'b00, 1'b0, 12'h010, 32'h00000055);
    @(posedge clk); #1;
    chk("rmw_in_write", {31'h0, MemStore}, 32'h1);
    chk("rmw_write_data", MemDataIn, 32'hA5A5A555);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("aborted_write_mem4", mem[4], 32'hA5A5A5A5);
    chk("aborted_no_rsp", {31'h0, RspValid}, 32'h0);

    // Recovery after reset.
    push(32'hA5A5A5A5, 1'b0, 8'd2, 8'd1, 8'd0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0); wait_rsp(++target);

    repeat (3) @(posedge clk); #1;
    chk("accept_count", acc_cnt, exp_acc);
    chk("load_store_overlap", both_cnt, 32'h0);
    chk("scoreboard_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The module SHALL have exactly one parameter: ADDR_W, default 12, width of the byte address; the word index is ReqAddr[ADDR_W-1:2], and the default gives 1024 words.
REQ-002 The module SHALL have the following ports, clock and reset first:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  unit can accept a request.
- ReqWe  in  1  1 = store, 0 = load.
- ReqSize  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word.
- ReqUnsigned  in  1  zero-extend sub-word loads.
- ReqAddr  in  ADDR_W  byte address.
- ReqData  in  32  store data, taken from the low bits.
- RspValid  out  1  response present.
- RspReady  in  1  consumer accepts the response.
- RspData  out  32  load result; 0 for stores.
- AddrErr  out  1  misaligned access; valid while RspValid is high.
- MemLoad  out  1  read strobe to the word memory.
- MemStore  out  1  write strobe to the word memory.
- MemAddress  out  ADDR_W-2  word index.
- MemDataIn  out  32  write data to the memory.
- MemDataOut  in  32  combinational read data from the memory; 0 when MemLoad is low.

Function
REQ-003 The FSM SHALL have five states: IDLE, LOAD, RMW_RD, WRITE, RESP.
REQ-004 ReqReady SHALL be 1 only in IDLE; a request is accepted on a rising edge with ReqValid=1 and ReqReady=1, and ReqWe, ReqSize, ReqUnsigned, ReqAddr and ReqData are latched on that edge.
REQ-005 Transitions out of IDLE on acceptance SHALL be:
- Misaligned access (half with addr[0]=1; word with addr[1:0]!=0) -> RESP with AddrErr=1 and no memory strobe.
- Load -> LOAD.
- Word store -> WRITE.
- Byte or half store -> RMW_RD.
REQ-006 In LOAD, MemLoad SHALL be 1; on the edge the extended lane is registered into RspData and the state moves to RESP.
REQ-007 Lanes SHALL be little-endian: byte n is bits [8n+7:8n]; half n is bits [16n+15:16n]; extension is sign or zero per the latched ReqUnsigned.
REQ-008 In RMW_RD, MemLoad SHALL be 1; the edge captures MemDataOut into a merge register and moves to WRITE.
REQ-009 In WRITE, MemStore SHALL be 1 and MemDataIn SHALL be the merge word with only the addressed lane(s) replaced (full ReqData for word stores); the state then moves to RESP.
REQ-010 MemLoad, MemStore and MemAddress SHALL be driven only from registered state and latched address, never combinationally from Req* inputs; MemLoad and MemStore SHALL never both be 1.
REQ-011 In RESP, RspValid SHALL be 1, and RspData and AddrErr SHALL be held stable until an edge with RspReady=1, which moves the state to IDLE.
REQ-012 Latency from acceptance edge to RspValid=1 SHALL be: error 1 cycle; load 2; word store 2; byte/half store 3.
REQ-013 ReqValid outside IDLE SHALL be ignored; a new request SHALL NOT be accepted in the same cycle a response is consumed.
REQ-014 RspData SHALL be 0 for stores and for errored accesses.

Reset
REQ-015 Asserting rst_n=0 SHALL immediately force the state to IDLE and set RspValid=0, RspData=0, AddrErr=0, MemLoad=0, MemStore=0, MemAddress=0, MemDataIn=0, and clear the merge register.
REQ-016 Reset asserted during RMW_RD or WRITE SHALL abort the access with no memory write on any later edge.

Configuration
REQ-017 With MISALIGN_TRAP_EN defined, REQ-005 misalignment detection SHALL apply.
REQ-018 With MISALIGN_TRAP_EN undefined, the offending low address bits SHALL be forced to 0, the access SHALL proceed normally, and AddrErr SHALL be constant 0.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Word 5 = 0x8899AABB; load byte addr 0x016, signed -> RspData=0xFFFFFF99, 2 cycles after acceptance.
- Same word; load half addr 0x016, unsigned -> RspData=0x00008899.
- Store byte 0xCC to addr 0x015 over 0x8899AABB -> one MemLoad cycle, then MemStore with MemDataIn=0x8899CCBB; RspValid 3 cycles after acceptance.
- Load word addr 0x00A with MISALIGN_TRAP_EN defined -> AddrErr=1, no strobe, RspValid after 1 cycle; with it undefined -> word 2 is read and AddrErr=0.
- RspReady held 0 for 4 cycles after a load -> RspValid and RspData are stable and ReqReady=0 throughout; a ReqValid pulse in this window is not accepted.
- rst_n pulsed low during WRITE of a byte store -> outputs are at reset values immediately and memory word is unchanged.
